// File: rtl/alu_cmd_sequencer_if.sv
// Host/accumulator bus of the ALU command sequencer.
// The host side (table writes, start, accumulator readback) is the master.
interface alu_cmd_sequencer_if;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [6:0] wr_data;
  logic       start;
  logic [2:0] last_idx;
  logic [7:0] acc_q;
  logic [3:0] alu_a;
  logic [2:0] alu_select;
  logic       acc_clear;
  logic       acc_load;
  logic       busy;
  logic       done;
  logic [2:0] step;
  logic [7:0] result;
  logic [7:0] checksum;

  modport master (
    output wr_en, wr_addr, wr_data, start, last_idx, acc_q,
    input  alu_a, alu_select, acc_clear, acc_load, busy, done, step, result, checksum
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, last_idx, acc_q,
    output alu_a, alu_select, acc_clear, acc_load, busy, done, step, result, checksum
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Replays an 8-entry {select, operand} table into the ALU/accumulator and
// reports the final accumulator value plus an XOR checksum of every step.
//
// state   | meaning
// IDLE    | waiting for start; table writable
// CLEAR   | one-cycle accumulator clear
// SETUP   | table[step] driven, settle counter running
// LOAD    | accumulator load strobe
// CAPTURE | fold acc_q into checksum; advance or finish
// DONE    | one-cycle completion pulse; table writable
module alu_cmd_sequencer #(
  parameter int SETTLE_CYCLES = 2
) (
  input logic                 clk,
  input logic                 reset,
  alu_cmd_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, CLEAR, SETUP, LOAD, CAPTURE, DONE} state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state, state_nxt;
  logic [6:0] cmd_tbl [8];
  logic [3:0] settle_cnt;
  logic [2:0] step_q;
  logic [2:0] last_q;
  logic [7:0] result_q;
  logic [7:0] checksum_q;
  logic       tbl_we;
  logic       drive_cmd;
  logic       is_last;

  assign is_last = (step_q == last_q);

  always_comb begin
    state_nxt     = state;
    tbl_we        = 1'b0;
    drive_cmd     = 1'b0;
    bus.acc_clear = 1'b0;
    bus.acc_load  = 1'b0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    case (state)
      IDLE: begin
        tbl_we = bus.wr_en;
        if (bus.start) state_nxt = CLEAR;
      end
      CLEAR: begin
        bus.acc_clear = 1'b1;
        bus.busy      = 1'b1;
        state_nxt     = SETUP;
      end
      SETUP: begin
        drive_cmd = 1'b1;
        bus.busy  = 1'b1;
        if (settle_cnt == 4'd0) state_nxt = LOAD;
      end
      LOAD: begin
        drive_cmd    = 1'b1;
        bus.busy     = 1'b1;
        bus.acc_load = 1'b1;
        state_nxt    = CAPTURE;
      end
      CAPTURE: begin
        drive_cmd = 1'b1;
        bus.busy  = 1'b1;
        state_nxt = is_last ? DONE : SETUP;
      end
      DONE: begin
        bus.done  = 1'b1;
        tbl_we    = bus.wr_en;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.alu_a      = drive_cmd ? cmd_tbl[step_q][3:0] : 4'd0;
  assign bus.alu_select = drive_cmd ? cmd_tbl[step_q][6:4] : 3'd0;
  assign bus.step       = step_q;
  assign bus.result     = result_q;
  assign bus.checksum   = checksum_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      settle_cnt <= 4'd0;
      step_q     <= 3'd0;
      last_q     <= 3'd0;
      result_q   <= 8'd0;
      checksum_q <= 8'd0;
      for (int i = 0; i < 8; i++) cmd_tbl[i] <= 7'd0;
    end else begin
      state <= state_nxt;
      if (tbl_we) cmd_tbl[bus.wr_addr] <= bus.wr_data;

      // Reload on every entry into SETUP so each command gets the full settle time.
      if (state_nxt == SETUP && state != SETUP) settle_cnt <= SETTLE_LOAD;
      else if (state == SETUP)                 settle_cnt <= settle_cnt - 4'd1;

      if (state == IDLE && bus.start) begin
        last_q     <= bus.last_idx;
        step_q     <= 3'd0;
        checksum_q <= 8'd0;
      end

      if (state == CAPTURE) begin
        checksum_q <= checksum_q ^ bus.acc_q;
        if (is_last) begin
          result_q <= bus.acc_q;
          step_q   <= 3'd0;
        end else begin
          step_q <= step_q + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural ALU/accumulator.
module tb_alu_cmd_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  alu_cmd_sequencer_if bus ();

  alu_cmd_sequencer #(.SETTLE_CYCLES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ALU ops used here: 001 add, 101 shift-in nibble, 110 multiply, others pass A.
  function automatic logic [7:0] alu_f(input logic [2:0] sel, input logic [3:0] a,
                                       input logic [7:0] acc);
    case (sel)
      3'b001:  return acc + {4'd0, a};
      3'b101:  return {acc[3:0], a};
      3'b110:  return 8'({4'd0, a} * {4'd0, acc[3:0]});
      default: return {4'd0, a};
    endcase
  endfunction

  logic [7:0] acc = 8'd0;
  logic [6:0] rec [64];
  int         load_cnt = 0;
  int         clr_cnt  = 0;

  assign bus.acc_q = acc;

  always @(posedge clk) begin
    if (bus.acc_clear)     acc <= 8'd0;
    else if (bus.acc_load) acc <= alu_f(bus.alu_select, bus.alu_a, acc);
    if (bus.acc_load) begin
      rec[load_cnt % 64] <= {bus.alu_select, bus.alu_a};
      load_cnt <= load_cnt + 1;
    end
    if (bus.acc_clear) clr_cnt <= clr_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic wr_tbl(input logic [2:0] addr, input logic [6:0] data);
    bus.wr_en = 1'b1; bus.wr_addr = addr; bus.wr_data = data;
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
  endtask

  // Starts a run (start sampled at the next edge, E0) and returns the number of
  // edges after E0 until done is seen. inj>0 pulses start + a write at that count.
  task automatic run(input logic [2:0] li, input int inj, output int cyc);
    bus.start = 1'b1; bus.last_idx = li;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.wr_en = 1'b0;
    chk("clear_after_e0", {31'd0, bus.acc_clear}, 32'd1);
    cyc = 0;
    while (cyc < 100) begin
      if (inj > 0 && cyc == inj) begin
        bus.start = 1'b1; bus.wr_en = 1'b1; bus.wr_addr = 3'd1; bus.wr_data = 7'h7F;
      end
      @(posedge clk); #1;
      bus.start = 1'b0; bus.wr_en = 1'b0;
      cyc++;
      if (bus.done) break;
    end
  endtask

  int cyc;
  int base;

  initial begin
    bus.wr_en = 1'b0; bus.wr_addr = 3'd0; bus.wr_data = 7'd0;
    bus.start = 1'b0; bus.last_idx = 3'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Idle after reset
    repeat (10) @(posedge clk);
    #1;
    chk("idle_outs", {bus.alu_a, bus.alu_select, bus.acc_clear, bus.acc_load,
                      bus.busy, bus.done, bus.step}, 32'd0);
    chk("idle_res_sum", {bus.result, bus.checksum}, 32'd0);
    chk("idle_pulses", load_cnt + clr_cnt, 32'd0);

    // Three-command run
    wr_tbl(3'd0, 7'b001_0011);
    wr_tbl(3'd1, 7'b001_0100);
    wr_tbl(3'd2, 7'b101_1001);
    base = load_cnt;
    run(3'd2, 0, cyc);
    chk("run3_done_at", cyc, 32'd13);
    chk("run3_result", bus.result, 32'h79);
    chk("run3_checksum", bus.checksum, 32'h7D);
    chk("run3_busy_in_done", {31'd0, bus.busy}, 32'd0);
    chk("run3_loads", load_cnt - base, 32'd3);
    chk("run3_cmd0", rec[base % 64], 32'h13);
    chk("run3_cmd2", rec[(base + 2) % 64], 32'h59);
    chk("run3_clears", clr_cnt, 32'd1);

    // Single command: 5 * cleared accumulator
    @(posedge clk); #1;
    wr_tbl(3'd0, 7'b110_0101);
    base = load_cnt;
    run(3'd0, 0, cyc);
    chk("run1_done_at", cyc, 32'd5);
    chk("run1_result_sum", {bus.result, bus.checksum}, 32'h0000);
    chk("run1_loads", load_cnt - base, 32'd1);

    // start + write mid-run are ignored
    @(posedge clk); #1;
    base = load_cnt;
    run(3'd2, 2, cyc);
    chk("midrun_done_at", cyc, 32'd13);
    chk("midrun_cmd1", rec[(base + 1) % 64], 32'h14);
    chk("midrun_result", bus.result, 32'h49);
    chk("midrun_checksum", bus.checksum, 32'h4D);
    repeat (4) @(posedge clk); #1;
    chk("midrun_loads", load_cnt - base, 32'd3);
    chk("midrun_no_restart", {31'd0, bus.busy}, 32'd0);

    // Reset during LOAD of command 1
    bus.start = 1'b1; bus.last_idx = 3'd2;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 0;
    while (cyc < 100 && !(bus.acc_load && bus.step == 3'd1)) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("rst_load_seen", {31'd0, bus.acc_load}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    base = load_cnt;
    chk("rst_outs", {bus.alu_a, bus.alu_select, bus.acc_clear, bus.acc_load,
                     bus.busy, bus.done, bus.step}, 32'd0);
    chk("rst_res_sum", {bus.result, bus.checksum}, 32'd0);
    reset = 1'b0;
    repeat (5) @(posedge clk); #1;
    chk("rst_no_loads", load_cnt - base, 32'd0);
    run(3'd1, 0, cyc);
    chk("rst_run_done_at", cyc, 32'd9);
    chk("rst_tbl0", rec[base % 64], 32'd0);
    chk("rst_tbl1", rec[(base + 1) % 64], 32'd0);

    // Write and start in the same cycle
    @(posedge clk); #1;
    bus.wr_en = 1'b1; bus.wr_addr = 3'd0; bus.wr_data = 7'b001_1111;
    base = load_cnt;
    run(3'd0, 0, cyc);
    chk("wrstart_done_at", cyc, 32'd5);
    chk("wrstart_result", bus.result, 32'h0F);
    chk("wrstart_checksum", bus.checksum, 32'h0F);
    chk("wrstart_cmd0", rec[base % 64], 32'h1F);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command initiator for the 4-bit ALU/accumulator datapath. It holds an 8-entry table of {select, operand} commands and, on start, clears the accumulator. It then replays the commands one at a time: drives ALU operand/select, waits for settling, strobes the accumulator load and reads back the result. It replaces manual switch/key stepping, so the accumulator can be exercised autonomously. It reports the final accumulator value and an XOR checksum of every intermediate value.

## Interface
- SETTLE_CYCLES, 2, cycles alu_a/alu_select are held before acc_load; legal 1..15
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; clears FSM, table, all outputs
- wr_en  in  1  table write strike (ignored while busy)
- wr_addr  in  3  table entry index
- wr_data  in  7  {select[2:0], operand[3:0]}
- start  in  1  begin run when idle (ignored while busy)
- last_idx  in  3  index of final command; run executes entries 0..last_idx; sampled with start
- acc_q  in  8  accumulator register readback
- alu_a  out  4  operand A to ALU
- alu_select  out  3  ALU function select
- acc_clear  out  1  one-cycle synchronous clear to accumulator
- acc_load  out  1  one-cycle load enable to accumulator
- busy  out  1  high from the cycle after start through the last CAPTURE
- done  out  1  one-cycle pulse, run complete
- step  out  3  index of command in progress (0 when idle)
- result  out  8  acc_q captured on final command; holds until next run
- checksum  out  8  XOR of acc_q captured after every command of the run

## Operation
- States: IDLE, CLEAR, SETUP, LOAD, CAPTURE, DONE.
- IDLE: alu_a=0, alu_select=0, acc_clear=0, acc_load=0, busy=0. start=1 latches last_idx, zeroes step and checksum, goes to CLEAR.
- CLEAR (1 cycle): acc_clear=1. Next state is SETUP.
- SETUP (SETTLE_CYCLES cycles): drive alu_a/alu_select from table[step]. An internal settle counter counts down. Exit to LOAD when the counter expires.
- LOAD (1 cycle): table[step] is still driven, acc_load=1.
- CAPTURE (1 cycle): table[step] is still driven; checksum <= checksum ^ acc_q.
  - If step==last_idx: result <= acc_q, go to DONE.
  - Otherwise step+1, go to SETUP.
- DONE (1 cycle): done=1, busy=0, alu_a/alu_select=0. Next state is IDLE.
- Table writes: in IDLE or DONE, wr_en writes table[wr_addr] <= wr_data at the clock edge. Writes in any other state are dropped.
- wr_en and start in the same IDLE cycle: the write commits. The run uses the new entry, since entry 0 is first read after CLEAR.
- last_idx=0 runs exactly one command. step never wraps; the run stops at last_idx.
- start during busy or DONE: ignored, no queuing.
- reset at any point, mid-run included:
  - Next cycle is IDLE.
  - All outputs and the table return to 0.
  - No acc_load is issued after reset.
- Reset values: alu_a=0, alu_select=0, acc_clear=0, acc_load=0, busy=0, done=0, step=0, result=0x00, checksum=0x00, table entries 7'b0.

## Timing
- Edge E0 samples start. CLEAR occupies the cycle after E0.
- Each command takes SETTLE_CYCLES+2 cycles.
- done is high in the cycle beginning at edge E0+1+N*(SETTLE_CYCLES+2), where N=last_idx+1.
- The accumulator samples on the edge ending LOAD. acc_q is valid throughout CAPTURE and is sampled on the edge ending CAPTURE.
- result and checksum update on the same edge as the transition into DONE. Both are stable while done=1.
- acc_load and acc_clear are never high in the same cycle. Each is high for exactly one cycle per event.
- alu_a/alu_select are stable from the first SETUP cycle through CAPTURE of each command.

## Test plan
- Reset then idle 10 cycles -> all outputs 0, no acc_clear/acc_load pulses.
- Bench accumulator model, SETTLE_CYCLES=2. Table {001,0011},{001,0100},{101,1001}, last_idx=2, start -> acc_q sequence 0x03, 0x07, 0x79; result=0x79; checksum=0x7D; done at E0+13.
- last_idx=0, table[0]={110,0101}, accumulator cleared -> one load, A*B=5*0 -> result=0x00, checksum=0x00, done at E0+5.
- Pulse start and wr_en(addr 1) mid-run -> no restart; table[1] unchanged; exactly last_idx+1 acc_load pulses.
- Assert reset during LOAD of command 1 -> IDLE next cycle, busy=0, no further acc_load, table reads 0.
- wr_en addr 0 ={001,1111} in the same cycle as start, last_idx=0 -> result=0x0F, checksum=0x0F.
